// File: rtl/iic_slave_reg_bridge.sv
// iic_slave_reg_bridge: byte-addressed register bank shared by the I2C slave
// byte streams and a fabric host port, with write notification and
// same-address write collision status.
// Optional feature macro: IIC_REG_WRITE_PROTECT_EN (drops I2C data writes to
// addresses >= RO_BASE; host writes remain unrestricted).
module iic_slave_reg_bridge #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter logic [7:0]  INIT_VALUE = 8'h00,
   parameter int unsigned RO_BASE    = (2**ADDR_WIDTH) - 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_wen,
   input  logic [7:0]            fifo_wdata,
   input  logic                  fifo_wdata_start,
   input  logic                  fifo_ren,
   output logic [7:0]            fifo_rdata,
   input  logic                  host_wen,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [7:0]            host_wdata,
   output logic [7:0]            host_rdata,
   output logic                  i2c_wr_strobe,
   output logic [ADDR_WIDTH-1:0] i2c_wr_addr,
   output logic [7:0]            i2c_wr_data,
   output logic                  collision,
   input  logic                  collision_clr,
   output logic [1:0]            bus_phase
);

   localparam int unsigned DEPTH = 2**ADDR_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [7:0]            mem [DEPTH];
   logic [ADDR_WIDTH-1:0] ptr_q;
   logic [ADDR_WIDTH-1:0] ptr_inc_c;
   logic                  ptr_load_c;
   logic                  data_c;
   logic                  rd_c;
   logic                  wr_ok_c;
   logic                  i2c_we_c;
   logic                  col_hit_c;

   // Write-protect window: I2C data writes at or above RO_BASE are dropped
`ifdef IIC_REG_WRITE_PROTECT_EN
   assign wr_ok_c = (32'(ptr_q) < RO_BASE);
`else
   logic unused_ro_base;
   assign unused_ro_base = ^RO_BASE;
   assign wr_ok_c        = 1'b1;
`endif

   assign ptr_inc_c = ADDR_WIDTH'(ptr_q + 1'b1);
   assign i2c_we_c  = data_c & wr_ok_c;
   assign col_hit_c = i2c_we_c & host_wen & (host_addr == ptr_q);
   assign bus_phase = state_q;

   // Phase register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next phase and stream decode; a write strobe masks a same-cycle read
   always_comb begin
      state_d    = state_q;
      ptr_load_c = 1'b0;
      data_c     = 1'b0;
      rd_c       = 1'b0;
      if (fifo_wen) begin
         state_d = ST_WRITE;
         if (fifo_wdata_start) ptr_load_c = 1'b1;
         else                  data_c     = 1'b1;
      end else if (fifo_ren) begin
         state_d = ST_READ;
         rd_c    = 1'b1;
      end
   end

   // Register bank; host write is issued last so it wins a same-address tie
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= INIT_VALUE;
      end else begin
         if (i2c_we_c) mem[ptr_q] <= fifo_wdata;
         if (host_wen) mem[host_addr] <= host_wdata;
      end
   end

   // Pointer, read ports, write notification and collision status
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q         <= '0;
         fifo_rdata    <= 8'h00;
         host_rdata    <= 8'h00;
         i2c_wr_strobe <= 1'b0;
         i2c_wr_addr   <= '0;
         i2c_wr_data   <= 8'h00;
         collision     <= 1'b0;
      end else begin
         host_rdata    <= mem[host_addr];
         i2c_wr_strobe <= i2c_we_c;
         if (ptr_load_c) begin
            ptr_q <= fifo_wdata[ADDR_WIDTH-1:0];
         end else if (data_c || rd_c) begin
            ptr_q <= ptr_inc_c;
         end
         if (rd_c) fifo_rdata <= mem[ptr_q];
         if (i2c_we_c) begin
            i2c_wr_addr <= ptr_q;
            i2c_wr_data <= fifo_wdata;
         end
         if (col_hit_c)          collision <= 1'b1;
         else if (collision_clr) collision <= 1'b0;
      end
   end

endmodule

// File: tb/tb_iic_slave_reg_bridge.sv
// Directed table-driven bench for iic_slave_reg_bridge (ADDR_WIDTH=4).
module tb_iic_slave_reg_bridge;

   localparam int unsigned AW = 4;
`ifdef IIC_REG_WRITE_PROTECT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fifo_wen;
   logic [7:0]    fifo_wdata;
   logic          fifo_wdata_start;
   logic          fifo_ren;
   logic [7:0]    fifo_rdata;
   logic          host_wen;
   logic [AW-1:0] host_addr;
   logic [7:0]    host_wdata;
   logic [7:0]    host_rdata;
   logic          i2c_wr_strobe;
   logic [AW-1:0] i2c_wr_addr;
   logic [7:0]    i2c_wr_data;
   logic          collision;
   logic          collision_clr;
   logic [1:0]    bus_phase;

   int n_chk  = 0;
   int n_fail = 0;

   iic_slave_reg_bridge #(.ADDR_WIDTH(AW), .INIT_VALUE(8'h00), .RO_BASE(12)) dut (
      .clk(clk), .rst_n(rst_n),
      .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .fifo_wdata_start(fifo_wdata_start),
      .fifo_ren(fifo_ren), .fifo_rdata(fifo_rdata),
      .host_wen(host_wen), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_rdata(host_rdata),
      .i2c_wr_strobe(i2c_wr_strobe), .i2c_wr_addr(i2c_wr_addr), .i2c_wr_data(i2c_wr_data),
      .collision(collision), .collision_clr(collision_clr), .bus_phase(bus_phase)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          wen;
      logic          start;
      logic [7:0]    wd;
      logic          ren;
      logic          hw;
      logic [AW-1:0] ha;
      logic [7:0]    hd;
      logic          clr;
      logic [7:0]    e_rd;
      logic          e_stb;
      logic [AW-1:0] e_a;
      logic [7:0]    e_d;
      logic          e_col;
      logic [1:0]    e_ph;
      logic          chk_h;
      logic [7:0]    e_h;
   } vec_t;

   function automatic vec_t mk(
      input logic wen, input logic start, input logic [7:0] wd, input logic ren,
      input logic hw, input logic [AW-1:0] ha, input logic [7:0] hd, input logic clr,
      input logic [7:0] e_rd, input logic e_stb, input logic [AW-1:0] e_a,
      input logic [7:0] e_d, input logic e_col, input logic [1:0] e_ph,
      input logic chk_h, input logic [7:0] e_h);
      vec_t v;
      v.wen = wen; v.start = start; v.wd = wd; v.ren = ren;
      v.hw = hw; v.ha = ha; v.hd = hd; v.clr = clr;
      v.e_rd = e_rd; v.e_stb = e_stb; v.e_a = e_a; v.e_d = e_d;
      v.e_col = e_col; v.e_ph = e_ph; v.chk_h = chk_h; v.e_h = e_h;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      fifo_wen = 1'b0; fifo_wdata = 8'h00; fifo_wdata_start = 1'b0; fifo_ren = 1'b0;
      host_wen = 1'b0; host_addr = '0; host_wdata = 8'h00; collision_clr = 1'b0;
   endtask

   // Drive one cycle of stimulus, then check the registered outputs after the edge
   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      fifo_wen = v.wen; fifo_wdata_start = v.start; fifo_wdata = v.wd; fifo_ren = v.ren;
      host_wen = v.hw; host_addr = v.ha; host_wdata = v.hd; collision_clr = v.clr;
      @(posedge clk);
      #1;
      chk({tag, " fifo_rdata"}, 32'(fifo_rdata), 32'(v.e_rd));
      chk({tag, " strobe"}, 32'(i2c_wr_strobe), 32'(v.e_stb));
      chk({tag, " collision"}, 32'(collision), 32'(v.e_col));
      chk({tag, " bus_phase"}, 32'(bus_phase), 32'(v.e_ph));
      if (v.e_stb) begin
         chk({tag, " wr_addr"}, 32'(i2c_wr_addr), 32'(v.e_a));
         chk({tag, " wr_data"}, 32'(i2c_wr_data), 32'(v.e_d));
      end
      if (v.chk_h) chk({tag, " host_rdata"}, 32'(host_rdata), 32'(v.e_h));
   endtask

   // Reset for one cycle while a data byte is also offered, then check reset state
   task automatic reset_check(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      fifo_wen = 1'b1; fifo_wdata_start = 1'b0; fifo_wdata = 8'h56;
      @(posedge clk);
      #1;
      chk({tag, " rst fifo_rdata"}, 32'(fifo_rdata), 32'h00);
      chk({tag, " rst host_rdata"}, 32'(host_rdata), 32'h00);
      chk({tag, " rst strobe"}, 32'(i2c_wr_strobe), 32'h0);
      chk({tag, " rst wr_addr"}, 32'(i2c_wr_addr), 32'h0);
      chk({tag, " rst wr_data"}, 32'(i2c_wr_data), 32'h00);
      chk({tag, " rst collision"}, 32'(collision), 32'h0);
      chk({tag, " rst bus_phase"}, 32'(bus_phase), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive_idle();
   endtask

   vec_t vecs[$];

   initial begin
      rst_n = 1'b0;
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      chk("init fifo_rdata", 32'(fifo_rdata), 32'h00);
      chk("init strobe", 32'(i2c_wr_strobe), 32'h0);
      chk("init collision", 32'(collision), 32'h0);
      chk("init bus_phase", 32'(bus_phase), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      //            wen st wd    ren hw ha  hd    clr  e_rd  stb a  d     col ph chk h
      // pointer + burst write
      vecs.push_back(mk(1, 1, 8'h02, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00));
      vecs.push_back(mk(1, 0, 8'hA1, 0, 0, 0, 8'h00, 0, 8'h00, 1, 2, 8'hA1, 0, 1, 0, 8'h00));
      vecs.push_back(mk(1, 0, 8'hB2, 0, 0, 0, 8'h00, 0, 8'h00, 1, 3, 8'hB2, 0, 1, 0, 8'h00));
      vecs.push_back(mk(1, 0, 8'hC3, 0, 0, 0, 8'h00, 0, 8'h00, 1, 4, 8'hC3, 0, 1, 0, 8'h00));
      vecs.push_back(mk(0, 0, 8'h00, 0, 0, 2, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 8'hA1));
      vecs.push_back(mk(0, 0, 8'h00, 0, 0, 4, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 8'hC3));
      // read burst from pointer 3, rdata holds between strobes
      vecs.push_back(mk(1, 1, 8'h03, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'hB2, 0, 0, 8'h00, 0, 2, 0, 8'h00));
      vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'hB2, 0, 0, 8'h00, 0, 2, 0, 8'h00));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'hC3, 0, 0, 8'h00, 0, 2, 0, 8'h00));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 2, 0, 8'h00));
      // wrap: pointer byte 1F loads 15 (upper bits ignored)
      vecs.push_back(mk(1, 1, 8'h1F, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00));
      vecs.push_back(mk(1, 0, 8'h11, 0, 0, 0, 8'h00, 0, 8'h00, 1, 15, 8'h11, 0, 1, 0, 8'h00));
      vecs.push_back(mk(1, 0, 8'h22, 0, 0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h22, 0, 1, 0, 8'h00));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 2, 0, 8'h00));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'hA1, 0, 0, 8'h00, 0, 2, 0, 8'h00));
      // wen beats a same-cycle ren
      vecs.push_back(mk(1, 1, 8'h06, 1, 0, 0, 8'h00, 0, 8'hA1, 0, 0, 8'h00, 0, 1, 0, 8'h00));
      // collision at 6: host wins, strobe carries I2C byte, host read is old value
      vecs.push_back(mk(1, 0, 8'h55, 0, 1, 6, 8'hAA, 0, 8'hA1, 1, 6, 8'h55, 1, 1, 1, 8'h00));
      vecs.push_back(mk(0, 0, 8'h00, 0, 0, 6, 8'h00, 0, 8'hA1, 0, 0, 8'h00, 1, 1, 1, 8'hAA));
      vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'hA1, 0, 0, 8'h00, 0, 1, 0, 8'h00));
      // set and clear in the same cycle: set wins
      vecs.push_back(mk(1, 0, 8'h66, 0, 1, 7, 8'h77, 1, 8'hA1, 1, 7, 8'h66, 1, 1, 0, 8'h00));
      vecs.push_back(mk(0, 0, 8'h00, 0, 0, 7, 8'h00, 1, 8'hA1, 0, 0, 8'h00, 0, 1, 1, 8'h77));
      // ren and host write to the same register: read returns old value
      vecs.push_back(mk(1, 1, 8'h08, 0, 0, 0, 8'h00, 0, 8'hA1, 0, 0, 8'h00, 0, 1, 0, 8'h00));
      vecs.push_back(mk(0, 0, 8'h00, 1, 1, 8, 8'h99, 0, 8'h00, 0, 0, 8'h00, 0, 2, 1, 8'h00));
      vecs.push_back(mk(1, 1, 8'h08, 0, 0, 8, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 8'h99));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h99, 0, 0, 8'h00, 0, 2, 0, 8'h00));

      foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

      // Reset mid-burst, then IDLE data byte at ptr 0 and read back of cleared bank
      apply(mk(1, 1, 8'h09, 0, 0, 0, 8'h00, 0, 8'h99, 0, 0, 8'h00, 0, 1, 0, 8'h00), "mid0");
      apply(mk(1, 0, 8'h12, 0, 0, 0, 8'h00, 0, 8'h99, 1, 9, 8'h12, 0, 1, 0, 8'h00), "mid1");
      apply(mk(1, 0, 8'h34, 0, 0, 0, 8'h00, 0, 8'h99, 1, 10, 8'h34, 0, 1, 0, 8'h00), "mid2");
      reset_check("mid");
      apply(mk(0, 0, 8'h00, 0, 0, 9, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h00), "post0");
      apply(mk(1, 0, 8'h5A, 0, 0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h5A, 0, 1, 0, 8'h00), "post1");
      apply(mk(1, 1, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00), "post2");
      apply(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h5A, 0, 0, 8'h00, 0, 2, 0, 8'h00), "post3");
      apply(mk(1, 1, 8'h0A, 0, 0, 0, 8'h00, 0, 8'h5A, 0, 0, 8'h00, 0, 1, 0, 8'h00), "post4");
      apply(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 2, 0, 8'h00), "post5");

      // Write-protect boundary at RO_BASE=12 (fully writable when feature is off)
      reset_check("prot");
      apply(mk(1, 1, 8'h0B, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00), "prot0");
      apply(mk(1, 0, 8'h01, 0, 0, 0, 8'h00, 0, 8'h00, 1, 11, 8'h01, 0, 1, 0, 8'h00), "prot1");
      apply(mk(1, 0, 8'h02, 0, 0, 0, 8'h00, 0, 8'h00, !PROT, 12, 8'h02, 0, 1, 0, 8'h00), "prot2");
      apply(mk(0, 0, 8'h00, 0, 0, 12, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1,
               PROT ? 8'h00 : 8'h02), "prot3");
      apply(mk(0, 0, 8'h00, 0, 1, 12, 8'hEE, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1,
               PROT ? 8'h00 : 8'h02), "prot4");
      apply(mk(0, 0, 8'h00, 0, 0, 12, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 8'hEE), "prot5");
      apply(mk(0, 0, 8'h00, 0, 0, 11, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 8'h01), "prot6");
      apply(mk(1, 1, 8'h0C, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00), "prot7");
      apply(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'hEE, 0, 0, 8'h00, 0, 2, 0, 8'h00), "prot8");

      @(negedge clk);
      drive_idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/iic_slave_reg_bridge.md
Name: iic_slave_reg_bridge

Overview:
Byte-addressed register bank behind the I2C slave interface. It consumes the slave's write-stream (fifo_wen/fifo_wdata/fifo_wdata_start) and serves its read-stream (fifo_ren/fifo_rdata). First byte of each write transaction loads a register pointer, and subsequent bytes write with auto-increment. Fabric logic gets a second, host-side port to the same bank, plus write-notification and collision status.

Parameters:
ADDR_WIDTH, 4, pointer/address width; bank depth = 2**ADDR_WIDTH bytes, legal range 1..8
INIT_VALUE, 8'h00, reset value of every register
RO_BASE, 2**ADDR_WIDTH - 4, first I2C-read-only address; used only when IIC_REG_WRITE_PROTECT_EN is defined

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
fifo_wen  in  1  one-cycle strobe, I2C byte received
fifo_wdata  in  8  received byte
fifo_wdata_start  in  1  qualifies fifo_wen: first byte after address/W, i.e. the pointer byte
fifo_ren  in  1  one-cycle strobe, I2C master needs next read byte
fifo_rdata  out  8  byte to shift out on I2C
host_wen  in  1  fabric write strobe
host_addr  in  ADDR_WIDTH  fabric address
host_wdata  in  8  fabric write data
host_rdata  out  8  mem[host_addr], registered
i2c_wr_strobe  out  1  pulse: I2C data byte committed
i2c_wr_addr  out  ADDR_WIDTH  address of committed byte
i2c_wr_data  out  8  committed byte
collision  out  1  sticky: host and I2C wrote same address in same cycle
collision_clr  in  1  clears collision
bus_phase  out  2  0 IDLE, 1 WRITE, 2 READ

Behaviour:
- Reset (rst_n=0 at posedge clk): all registers = INIT_VALUE; ptr=0; fifo_rdata=8'h00; host_rdata=8'h00; i2c_wr_strobe=0; i2c_wr_addr=0; i2c_wr_data=8'h00; collision=0; bus_phase=IDLE. Reset mid-transaction discards pointer and pending strobes.
- FSM states: IDLE, WRITE, READ. Priority per cycle is fifo_wen over fifo_ren; ren in the same cycle as wen is ignored.
- fifo_wen & fifo_wdata_start: ptr <= fifo_wdata[ADDR_WIDTH-1:0], upper bits ignored; no register write; next state WRITE.
- fifo_wen & !fifo_wdata_start: mem[ptr] <= fifo_wdata; ptr <= ptr+1 modulo depth (DEPTH-1 wraps to 0); i2c_wr_strobe=1 next cycle with i2c_wr_addr=old ptr and i2c_wr_data=byte; next state WRITE. A data byte in IDLE uses ptr=0 and is legal.
- fifo_ren: fifo_rdata <= mem[ptr] one cycle after the strobe; ptr <= ptr+1 with wrap; next state READ. Repeated-start read after a write pointer reads from the loaded pointer. fifo_rdata holds between strobes.
- Read-after-write same cycle boundary: if fifo_ren addresses a register written by host in the same cycle, fifo_rdata returns the old value (read-before-write).
- host_rdata <= mem[host_addr] every cycle, latency 1, read-before-write.
- host_wen: mem[host_addr] <= host_wdata.
- Same-cycle I2C data write and host_wen to the same address: host value wins, i2c_wr_strobe still pulses with the I2C data, collision <= 1. collision_clr clears; a set in the same cycle wins over clear.
- i2c_wr_strobe is exactly one cycle wide per committed byte.

Optional Feature:
IIC_REG_WRITE_PROTECT_EN
- Defined: I2C data writes to addresses >= RO_BASE are dropped. ptr still increments, no i2c_wr_strobe, no collision. Host writes are unaffected.
- Undefined: all addresses are I2C-writable, and RO_BASE is unused.

Test Plan:
- Pointer+burst: start byte 8'h02, then bytes A1,B2,C3 -> mem[2..4]=A1,B2,C3, three i2c_wr_strobe pulses with addr 2,3,4, bus_phase=WRITE.
- Wrap: pointer 8'h0F (ADDR_WIDTH=4), bytes 11,22 -> mem[15]=11, mem[0]=22; ptr=1.
- Read burst: after pointer 8'h03, three fifo_ren -> fifo_rdata = mem[3],mem[4],mem[5], each one cycle after its strobe; bus_phase=READ.
- Collision: I2C write 55 and host_wen AA to address 6 in the same cycle -> mem[6]=AA, i2c_wr_data=55, collision=1; collision_clr -> 0.
- Reset mid-burst: rst_n low after two data bytes -> all mem=INIT_VALUE, ptr=0, bus_phase=IDLE; next ren returns INIT_VALUE.
- With IIC_REG_WRITE_PROTECT_EN and RO_BASE=12: pointer 8'h0B, bytes 01,02 -> mem[11]=01, mem[12] unchanged, one strobe only; host write to 12 succeeds.
